// File: rtl/cpu_axi_bridge_arbiter_pkg.sv
// cpu_axi_bridge_arbiter_pkg: shared AXI IDs, FSM state encodings and size codes
package cpu_axi_bridge_arbiter_pkg;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic {RQ_IDLE, RQ_AR} rq_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;
endpackage

// File: rtl/cpu_axi_bridge_arbiter_axi_wr_ctrl.sv
// axi_wr_ctrl: single-beat AXI write FSM; latches the data-side store and drives aw/w, waits for b
module axi_wr_ctrl
  import cpu_axi_bridge_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic [3:0]        strb,
  input  logic [DATA_W-1:0] din,
  output logic              accept,
  output logic              done,
  output logic              active,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid
);
  w_state_e          state_q;
  logic              awvalid_q, wvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [3:0]        strb_q;
  logic [DATA_W-1:0] data_q;

  assign accept  = state_q == W_IDLE && req;
  assign done    = state_q == W_RESP && bvalid;
  assign active  = state_q != W_IDLE;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awvalid = awvalid_q;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign wvalid  = wvalid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        W_IDLE: if (req) begin
          state_q   <= W_SEND;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          addr_q    <= addr;
          size_q    <= size;
          strb_q    <= strb;
          data_q    <= din;
        end
        W_SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready) wvalid_q <= 1'b0;
          // aw and w complete independently; leave only once both are done
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_q <= W_RESP;
        end
        W_RESP: if (bvalid) state_q <= W_IDLE;
        default: state_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/cpu_axi_bridge_arbiter.sv
// cpu_axi_bridge_arbiter: shares one AXI master between inst fetch and data SRAM-like ports.
// Define ARB_RR_EN for round-robin read arbitration; default is fixed data-over-inst priority.
module cpu_axi_bridge_arbiter
  import cpu_axi_bridge_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);
  rq_state_e         rq_q;
  logic              inst_busy_q, data_busy_q, ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q, wr_addr;
  logic [1:0]        ar_size_q;
  logic              wr_accept, wr_done, wr_active;
  logic              hazard, inst_cand, data_cand, prefer_data, inst_go, data_go;
  logic              unused_ok;

  assign unused_ok = ^{inst_wr, rid[3:1]};

  axi_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
    .clk(clk), .resetn(resetn),
    .req(data_req && data_wr && !data_busy_q),
    .addr(data_addr), .size(data_size), .strb(data_wstrb), .din(data_wdata),
    .accept(wr_accept), .done(wr_done), .active(wr_active),
    .awaddr(wr_addr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bvalid(bvalid)
  );

  // fetches to the word of an in-flight store wait until the store completes
  assign hazard    = wr_active && inst_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2];
  assign inst_cand = inst_req && !inst_busy_q && !hazard;
  assign data_cand = data_req && !data_wr && !data_busy_q;
  assign data_go   = rq_q == RQ_IDLE && data_cand && (prefer_data || !inst_cand);
  assign inst_go   = rq_q == RQ_IDLE && inst_cand && !data_go;

`ifdef ARB_RR_EN
  logic last_grant_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_grant_q <= ID_INST;
    else if (inst_go || data_go) last_grant_q <= data_go ? ID_DATA : ID_INST;
  end
  assign prefer_data = last_grant_q == ID_INST;
`else
  assign prefer_data = 1'b1;
`endif

  assign inst_addr_ok = inst_go;
  assign data_addr_ok = data_go || wr_accept;
  assign inst_data_ok = rvalid && rid[0] == ID_INST;
  assign data_data_ok = (rvalid && rid[0] == ID_DATA) || wr_done;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign arvalid      = rq_q == RQ_AR;
  assign arid         = {3'b000, ar_id_q};
  assign araddr       = ar_addr_q;
  assign arsize       = {1'b0, ar_size_q};
  assign awaddr       = wr_addr;
  assign rready       = 1'b1;
  assign bready       = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rq_q        <= RQ_IDLE;
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
      ar_id_q     <= ID_INST;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
    end else begin
      inst_busy_q <= inst_go || (inst_busy_q && !inst_data_ok);
      data_busy_q <= data_addr_ok || (data_busy_q && !data_data_ok);
      case (rq_q)
        RQ_IDLE: if (data_go || inst_go) begin
          rq_q      <= RQ_AR;
          ar_id_q   <= data_go ? ID_DATA : ID_INST;
          ar_addr_q <= data_go ? data_addr : inst_addr;
          ar_size_q <= data_go ? data_size : inst_size;
        end
        RQ_AR: if (arready) rq_q <= RQ_IDLE;
        default: rq_q <= RQ_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_axi_bridge_arbiter.sv
// tb_cpu_axi_bridge_arbiter: directed scenarios with a response scoreboard for both requesters
module tb_cpu_axi_bridge_arbiter;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, rid = 0;
  logic [31:0] araddr, rdata = 0, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [3:0]  wstrb;

  typedef struct {bit wr; logic [31:0] d;} dexp_t;
  logic [31:0] iq[$];
  dexp_t       dq[$];
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_d(input bit wr, input logic [31:0] d);
    dexp_t e;
    e.wr = wr;
    e.d  = d;
    dq.push_back(e);
  endtask

  always @(negedge clk) begin
    dexp_t e;
    if (resetn) begin
      if (inst_data_ok) begin
        if (iq.size() == 0) check("inst_ok_unexpected", inst_data_ok, 0);
        else check("inst_rdata", inst_rdata, iq.pop_front());
      end
      if (data_data_ok) begin
        if (dq.size() == 0) check("data_ok_unexpected", data_data_ok, 0);
        else begin
          e = dq.pop_front();
          check("data_src", {rvalid && rid[0], bvalid}, e.wr ? 2'b01 : 2'b10);
          if (!e.wr) check("data_rdata", data_rdata, e.d);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    check("rst_readys", {rready, bready}, 2'b11);
    resetn = 1;
    // single inst read
    tick(); inst_req = 1; inst_size = 2; inst_addr = 32'h1c000000;
    @(negedge clk); check("s1_aok", inst_addr_ok, 1); check("s1_arv_pre", arvalid, 0);
    tick(); inst_req = 0;
    @(negedge clk); check("s1_arvalid", arvalid, 1); check("s1_araddr", araddr, 32'h1c000000);
    check("s1_arid", arid, 0); check("s1_arsize", arsize, 2); check("s1_aok_once", inst_addr_ok, 0);
    tick();
    @(negedge clk); check("s1_arv_hold", arvalid, 1); check("s1_araddr_hold", araddr, 32'h1c000000);
    tick(); arready = 1;
    @(negedge clk); check("s1_arv_hs", arvalid, 1);
    tick(); arready = 0;
    @(negedge clk); check("s1_arv_drop", arvalid, 0);
    tick(); iq.push_back(32'h02800c0c); rvalid = 1; rid = 0; rdata = 32'h02800c0c;
    tick(); rvalid = 0;
    // contention: data wins, inst follows
    inst_req = 1; inst_addr = 32'h1c000004; data_req = 1; data_wr = 0; data_addr = 32'h100; data_size = 2;
    @(negedge clk); check("s2_data_aok", data_addr_ok, 1); check("s2_inst_wait", inst_addr_ok, 0);
    tick(); data_req = 0; arready = 1;
    @(negedge clk); check("s2_arid_d", arid, 1); check("s2_araddr_d", araddr, 32'h100);
    check("s2_inst_wait2", inst_addr_ok, 0);
    tick(); arready = 0;
    @(negedge clk); check("s2_inst_aok", inst_addr_ok, 1);
    tick(); inst_req = 0; arready = 1;
    @(negedge clk); check("s2_arid_i", arid, 0); check("s2_araddr_i", araddr, 32'h1c000004);
    tick(); arready = 0;
    // out-of-order return: data first
    push_d(0, 32'h0000d0d0); rvalid = 1; rid = 1; rdata = 32'h0000d0d0;
    @(negedge clk); check("s2_inst_quiet", inst_data_ok, 0);
    tick(); iq.push_back(32'h11112222); rid = 0; rdata = 32'h11112222;
    @(negedge clk); check("s2_data_quiet", data_data_ok, 0);
    tick(); rvalid = 0;
    // byte store, aw before w, then RAW hazard on the same word
    data_req = 1; data_wr = 1; data_addr = 32'h203; data_size = 0; data_wstrb = 4'b1000; data_wdata = 32'habababab;
    @(negedge clk); check("s3_aok", data_addr_ok, 1); check("s3_awv_pre", awvalid, 0);
    tick(); data_req = 0; awready = 1;
    @(negedge clk); check("s3_awvalid", awvalid, 1); check("s3_wvalid", wvalid, 1);
    check("s3_awaddr", awaddr, 32'h203); check("s3_awsize", awsize, 0);
    check("s3_wstrb", wstrb, 4'b1000); check("s3_wdata", wdata, 32'habababab);
    tick(); awready = 0; wready = 1;
    @(negedge clk); check("s3_aw_drop", awvalid, 0); check("s3_w_hold", wvalid, 1);
    tick(); wready = 0; inst_req = 1; inst_addr = 32'h200;
    @(negedge clk); check("s3_w_drop", wvalid, 0); check("s3_no_early_ok", data_data_ok, 0);
    check("s3_hazard1", inst_addr_ok, 0);
    tick();
    @(negedge clk); check("s3_hazard2", inst_addr_ok, 0);
    tick(); push_d(1, 0); bvalid = 1;
    @(negedge clk); check("s3_bok", data_data_ok, 1); check("s3_hazard3", inst_addr_ok, 0);
    tick(); bvalid = 0;
    @(negedge clk); check("s3_retry_aok", inst_addr_ok, 1); check("s3_one_ok", data_data_ok, 0);
    tick(); inst_req = 0; arready = 1;
    @(negedge clk); check("s3_araddr", araddr, 32'h200);
    tick(); arready = 0; iq.push_back(32'h5555aaaa); rvalid = 1; rid = 0; rdata = 32'h5555aaaa;
    tick(); rvalid = 0;
    // different word during a pending store; r for inst and b together
    data_req = 1; data_wr = 1; data_addr = 32'h200; data_size = 2; data_wstrb = 4'hf; data_wdata = 32'h12345678;
    @(negedge clk); check("s4_aok", data_addr_ok, 1);
    tick(); data_req = 0; inst_req = 1; inst_addr = 32'h300;
    @(negedge clk); check("s4_nohazard", inst_addr_ok, 1);
    tick(); inst_req = 0; arready = 1; awready = 1; wready = 1;
    @(negedge clk); check("s4_araddr", araddr, 32'h300); check("s4_aw_w", {awvalid, wvalid}, 2'b11);
    tick(); arready = 0; awready = 0; wready = 0;
    @(negedge clk); check("s4_drop", {awvalid, wvalid, arvalid}, 0);
    tick(); iq.push_back(32'h0badf00d); push_d(1, 0); rvalid = 1; rid = 0; rdata = 32'h0badf00d; bvalid = 1;
    @(negedge clk); check("s4_both_ok", {inst_data_ok, data_data_ok}, 2'b11);
    tick(); rvalid = 0; bvalid = 0;
    // reset while in W_SEND
    data_req = 1; data_wr = 1; data_addr = 32'h400; data_wdata = 32'hcafef00d;
    tick(); data_req = 0;
    @(negedge clk); check("s5_awv_pre", awvalid, 1);
    #2 resetn = 0;
    #1 check("s5_rst_aw_w_ar", {awvalid, wvalid, arvalid}, 0);
    check("s5_rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    tick(); tick(); resetn = 1;
    data_req = 1; data_addr = 32'h404; data_wdata = 32'h600dcafe;
    @(negedge clk); check("s5_aok", data_addr_ok, 1);
    tick(); data_req = 0; awready = 1; wready = 1;
    @(negedge clk); check("s5_awaddr", awaddr, 32'h404); check("s5_wdata", wdata, 32'h600dcafe);
    check("s5_aw_w", {awvalid, wvalid}, 2'b11);
    tick(); awready = 0; wready = 0;
    @(negedge clk); check("s5_drop", {awvalid, wvalid}, 0);
    tick(); push_d(1, 0); bvalid = 1;
    @(negedge clk); check("s5_bok", data_data_ok, 1);
    tick(); bvalid = 0;
    tick();
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
